// File: rtl/ui_call_ctrl_if.sv
// ui_call_ctrl_if
//   Bundles the signals that pass between the call-control FSM and the button,
//   keypad and application layers.
//   master : the user-interface/application side. It drives the button pulses,
//            the keypad digits, the status codes and cmd_ack.
//   slave  : the ui_call_ctrl controller. It drives the state, cursor, dial
//            buffer, command channel and timed_out.
interface ui_call_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int MENU_ITEMS = 4
);
    logic                                 init;
    logic                                 enter;
    logic                                 up;
    logic                                 down;
    logic                                 left;
    logic                                 right;
    logic                                 digit_valid;
    logic [3:0]                           digit;
    logic [2:0]                           inc_command;
    logic                                 cmd_ack;
    logic [2:0]                           command;
    logic                                 command_valid;
    logic [2:0]                           current_state;
    logic [$clog2(MENU_ITEMS)-1:0]        current_menu_item;
    logic [4*NUM_DIGITS-1:0]              phn_num;
    logic [$clog2(NUM_DIGITS+1)-1:0]      digit_count;
    logic                                 timed_out;

    modport master (
        output init, enter, up, down, left, right, digit_valid, digit,
               inc_command, cmd_ack,
        input  command, command_valid, current_state, current_menu_item,
               phn_num, digit_count, timed_out
    );

    modport slave (
        input  init, enter, up, down, left, right, digit_valid, digit,
               inc_command, cmd_ack,
        output command, command_valid, current_state, current_menu_item,
               phn_num, digit_count, timed_out
    );
endinterface

// File: rtl/ui_call_ctrl.sv
// ui_call_ctrl
//   Call-control and menu FSM for the telephony user interface.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high
//     bus   : ui_call_ctrl_if.slave. Inputs are the buttons, the keypad and
//             the status codes. Outputs are the state, the cursor, the dial
//             buffer and the command channel.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   INIT     | waiting for enter/init after reset
//   IDLE     | home screen
//   MENU     | main menu; item 0 opens the dialler
//   DIALING  | collecting digits into the dial buffer
//   OUTGOING | CALL issued, ringing far end (timed)
//   INCOMING | incoming call; item 0=REJECT, 1=ACCEPT (timed)
//   BUSY     | call in progress; item 0=CALLER_ID, 1=END
//   ENDING   | HANGUP issued, waiting for call-ended status (timed)
module ui_call_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int MENU_ITEMS   = 4,
    parameter int RING_TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    ui_call_ctrl_if.slave     bus
);
    localparam int IW = $clog2(MENU_ITEMS);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int TW = $clog2(RING_TIMEOUT);

    typedef enum logic [2:0] {
        S_INIT = 3'd0, S_IDLE = 3'd1, S_MENU = 3'd2, S_DIALING = 3'd3,
        S_OUTGOING = 3'd4, S_INCOMING = 3'd5, S_BUSY = 3'd6, S_ENDING = 3'd7
    } state_t;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_CALL   = 3'd1;
    localparam logic [2:0] CMD_ACCEPT = 3'd2;
    localparam logic [2:0] CMD_REJECT = 3'd3;
    localparam logic [2:0] CMD_HANGUP = 3'd4;

    localparam logic [2:0] INC_CONNECTED = 3'd1;
    localparam logic [2:0] INC_INCOMING  = 3'd5;
    localparam logic [2:0] INC_ENDED     = 3'd6;

    state_t                  r_state, w_state_n;
    logic [IW-1:0]           r_item, w_item_n;
    logic [4*NUM_DIGITS-1:0] r_phn, w_phn_n;
    logic [CW-1:0]           r_cnt, w_cnt_n;
    logic [2:0]              r_cmd, w_cmd_n;
    logic                    r_cmd_valid, w_valid_n;
    logic [TW-1:0]           r_timer, w_timer_n;
    logic                    r_timed_out, w_to_n;

    logic w_timing, w_tc, w_any_btn, w_digit_ok;

    assign w_timing   = (r_state == S_OUTGOING) || (r_state == S_INCOMING) ||
                        (r_state == S_ENDING);
    assign w_tc       = w_timing && (r_timer == TW'(RING_TIMEOUT - 1));
    assign w_any_btn  = bus.enter | bus.left | bus.right | bus.up | bus.down;
    assign w_digit_ok = bus.digit_valid && (bus.digit <= 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_item      <= '0;
            r_phn       <= '0;
            r_cnt       <= '0;
            r_cmd       <= CMD_NONE;
            r_cmd_valid <= 1'b0;
            r_timer     <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_item      <= w_item_n;
            r_phn       <= w_phn_n;
            r_cnt       <= w_cnt_n;
            r_cmd       <= w_cmd_n;
            r_cmd_valid <= w_valid_n;
            r_timer     <= w_timer_n;
            r_timed_out <= w_to_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_item_n  = r_item;
        w_phn_n   = r_phn;
        w_cnt_n   = r_cnt;
        w_cmd_n   = r_cmd;
        w_valid_n = r_cmd_valid;
        w_to_n    = 1'b0;
        w_timer_n = w_timing ? r_timer + TW'(1) : '0;

        // Retire the pending command on ack. A command issued later in this
        // block overrides the retirement, which lets a timeout HANGUP win.
        if (r_cmd_valid && bus.cmd_ack) begin
            w_cmd_n   = CMD_NONE;
            w_valid_n = 1'b0;
        end

        case (r_state)
            S_INIT: begin
                if (bus.enter || bus.init) w_state_n = S_IDLE;
            end
            S_IDLE: begin
                if (bus.inc_command == INC_INCOMING) w_state_n = S_INCOMING;
                else if (bus.right)                  w_state_n = S_MENU;
            end
            S_MENU: begin
                if (bus.inc_command == INC_INCOMING) w_state_n = S_INCOMING;
                else if (bus.enter && r_item == '0) begin
                    w_state_n = S_DIALING;
                    w_phn_n   = '0;
                    w_cnt_n   = '0;
                end
                else if (bus.left) w_state_n = S_IDLE;
                else if (bus.up)
                    w_item_n = (r_item == '0) ? IW'(MENU_ITEMS - 1) : r_item - IW'(1);
                else if (bus.down)
                    w_item_n = (r_item == IW'(MENU_ITEMS - 1)) ? '0 : r_item + IW'(1);
            end
            S_DIALING: begin
                if (bus.inc_command == INC_INCOMING) w_state_n = S_INCOMING;
                else if (bus.enter) begin
                    if (r_cnt != '0 && !r_cmd_valid) begin
                        w_cmd_n   = CMD_CALL;
                        w_valid_n = 1'b1;
                        w_state_n = S_OUTGOING;
                    end
                end
                else if (bus.left) begin
                    if (r_cnt == '0) w_state_n = S_MENU;
                    else begin
                        for (int i = 0; i < NUM_DIGITS; i++)
                            if (CW'(i) == r_cnt - CW'(1)) w_phn_n[4*i +: 4] = 4'd0;
                        w_cnt_n = r_cnt - CW'(1);
                    end
                end
                else if (!w_any_btn && w_digit_ok && r_cnt < CW'(NUM_DIGITS)) begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (CW'(i) == r_cnt) w_phn_n[4*i +: 4] = bus.digit;
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            S_OUTGOING: begin
                if (bus.inc_command == INC_CONNECTED)  w_state_n = S_BUSY;
                else if (bus.inc_command == INC_ENDED) w_state_n = S_IDLE;
                else if (w_tc) begin
                    // Timeout HANGUP replaces any unacknowledged command.
                    w_cmd_n   = CMD_HANGUP;
                    w_valid_n = 1'b1;
                    w_to_n    = 1'b1;
                    w_state_n = S_ENDING;
                end
            end
            S_INCOMING: begin
                if (bus.inc_command == INC_ENDED) w_state_n = S_IDLE;
                else if (w_tc) begin
                    w_to_n    = 1'b1;
                    w_state_n = S_IDLE;
                end
                else if (bus.enter) begin
                    if (!r_cmd_valid) begin
                        w_cmd_n   = (r_item == IW'(1)) ? CMD_ACCEPT : CMD_REJECT;
                        w_valid_n = 1'b1;
                        w_state_n = (r_item == IW'(1)) ? S_BUSY : S_IDLE;
                    end
                end
                else if (bus.up || bus.down) w_item_n = r_item ^ IW'(1);
            end
            S_BUSY: begin
                if (bus.inc_command == INC_ENDED) w_state_n = S_IDLE;
                else if (bus.enter) begin
                    if (r_item == IW'(1) && !r_cmd_valid) begin
                        w_cmd_n   = CMD_HANGUP;
                        w_valid_n = 1'b1;
                        w_state_n = S_ENDING;
                    end
                end
                else if (bus.up || bus.down) w_item_n = r_item ^ IW'(1);
            end
            S_ENDING: begin
                if (bus.inc_command == INC_ENDED) w_state_n = S_IDLE;
                else if (w_tc) begin
                    w_to_n    = 1'b1;
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_INIT;
        endcase

        if (w_state_n != r_state) begin
            w_item_n  = '0;
            w_timer_n = '0;
        end
    end

    always_comb begin
        bus.current_state     = r_state;
        bus.current_menu_item = r_item;
        bus.phn_num           = r_phn;
        bus.digit_count       = r_cnt;
        bus.command           = r_cmd;
        bus.command_valid     = r_cmd_valid;
        bus.timed_out         = r_timed_out;
    end
endmodule

// File: tb/tb_ui_call_ctrl.sv
module tb_ui_call_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ui_call_ctrl_if #(.NUM_DIGITS(4), .MENU_ITEMS(4)) u_if ();

    ui_call_ctrl #(.NUM_DIGITS(4), .MENU_ITEMS(4), .RING_TIMEOUT(20)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 enter, 1 left, 2 right, 3 up, 4 down, 5 init
    task automatic press(input int b);
        case (b)
            0: u_if.enter = 1'b1;
            1: u_if.left  = 1'b1;
            2: u_if.right = 1'b1;
            3: u_if.up    = 1'b1;
            4: u_if.down  = 1'b1;
            default: u_if.init = 1'b1;
        endcase
        tick();
        u_if.enter = 1'b0; u_if.left = 1'b0; u_if.right = 1'b0;
        u_if.up = 1'b0; u_if.down = 1'b0; u_if.init = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        u_if.digit_valid = 1'b1;
        u_if.digit = d;
        tick();
        u_if.digit_valid = 1'b0;
        u_if.digit = 4'd0;
    endtask

    task automatic status(input logic [2:0] c);
        u_if.inc_command = c;
        tick();
        u_if.inc_command = 3'd0;
    endtask

    task automatic ack();
        u_if.cmd_ack = 1'b1;
        tick();
        u_if.cmd_ack = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (u_if.current_state !== 3'd0 || u_if.current_menu_item !== 2'd0 ||
            u_if.phn_num !== 16'h0 || u_if.digit_count !== 3'd0 || u_if.command !== 3'd0 ||
            u_if.command_valid !== 1'b0 || u_if.timed_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: state=%0d item=%0d phn=%h cnt=%0d cmd=%0d valid=%0b to=%0b, required all zero",
                     u_if.current_state, u_if.current_menu_item, u_if.phn_num, u_if.digit_count,
                     u_if.command, u_if.command_valid, u_if.timed_out);
        end
    endtask

    task automatic test_menu();
        press(0);
        n_cmp++;
        if (u_if.current_state !== 3'd1) begin n_bad++;
            $display("FAIL init_enter: state=%0d required 1", u_if.current_state); end
        status(3'd1);
        n_cmp++;
        if (u_if.current_state !== 3'd1) begin n_bad++;
            $display("FAIL idle_ignore_inc1: state=%0d required 1", u_if.current_state); end
        press(2);
        n_cmp++;
        if (u_if.current_state !== 3'd2 || u_if.current_menu_item !== 2'd0) begin n_bad++;
            $display("FAIL menu_entry: state=%0d item=%0d required 2/0", u_if.current_state, u_if.current_menu_item); end
        press(3);
        n_cmp++;
        if (u_if.current_menu_item !== 2'd3) begin n_bad++;
            $display("FAIL menu_up_wrap: item=%0d required 3", u_if.current_menu_item); end
        press(4);
        n_cmp++;
        if (u_if.current_menu_item !== 2'd0) begin n_bad++;
            $display("FAIL menu_down_wrap: item=%0d required 0", u_if.current_menu_item); end
        press(4);
        press(4);
        n_cmp++;
        if (u_if.current_menu_item !== 2'd2) begin n_bad++;
            $display("FAIL menu_down_twice: item=%0d required 2", u_if.current_menu_item); end
        press(0);
        n_cmp++;
        if (u_if.current_state !== 3'd2 || u_if.current_menu_item !== 2'd2) begin n_bad++;
            $display("FAIL menu_enter_noop: state=%0d item=%0d required 2/2", u_if.current_state, u_if.current_menu_item); end
        press(1);
        n_cmp++;
        if (u_if.current_state !== 3'd1 || u_if.current_menu_item !== 2'd0) begin n_bad++;
            $display("FAIL menu_left: state=%0d item=%0d required 1/0", u_if.current_state, u_if.current_menu_item); end
    endtask

    task automatic test_incoming_accept();
        status(3'd5);
        n_cmp++;
        if (u_if.current_state !== 3'd5 || u_if.current_menu_item !== 2'd0) begin n_bad++;
            $display("FAIL incoming_entry: state=%0d item=%0d required 5/0", u_if.current_state, u_if.current_menu_item); end
        press(4);
        n_cmp++;
        if (u_if.current_menu_item !== 2'd1) begin n_bad++;
            $display("FAIL incoming_toggle: item=%0d required 1", u_if.current_menu_item); end
        press(0);
        n_cmp++;
        if (u_if.current_state !== 3'd6 || u_if.command !== 3'd2 || u_if.command_valid !== 1'b1) begin n_bad++;
            $display("FAIL accept_issue: state=%0d cmd=%0d valid=%0b required 6/2/1",
                     u_if.current_state, u_if.command, u_if.command_valid); end
        tick();
        n_cmp++;
        if (u_if.command !== 3'd2 || u_if.command_valid !== 1'b1) begin n_bad++;
            $display("FAIL accept_hold: cmd=%0d valid=%0b required 2/1", u_if.command, u_if.command_valid); end
        ack();
        n_cmp++;
        if (u_if.command !== 3'd0 || u_if.command_valid !== 1'b0) begin n_bad++;
            $display("FAIL accept_ack: cmd=%0d valid=%0b required 0/0", u_if.command, u_if.command_valid); end
    endtask

    task automatic test_busy_hangup();
        press(4);
        n_cmp++;
        if (u_if.current_menu_item !== 2'd1 || u_if.current_state !== 3'd6) begin n_bad++;
            $display("FAIL busy_toggle: state=%0d item=%0d required 6/1", u_if.current_state, u_if.current_menu_item); end
        press(0);
        n_cmp++;
        if (u_if.current_state !== 3'd7 || u_if.command !== 3'd4 || u_if.command_valid !== 1'b1) begin n_bad++;
            $display("FAIL busy_hangup: state=%0d cmd=%0d valid=%0b required 7/4/1",
                     u_if.current_state, u_if.command, u_if.command_valid); end
        status(3'd6);
        repeat (3) tick();
        n_cmp++;
        if (u_if.current_state !== 3'd1 || u_if.command !== 3'd4 || u_if.command_valid !== 1'b1) begin n_bad++;
            $display("FAIL ended_cmd_held: state=%0d cmd=%0d valid=%0b required 1/4/1",
                     u_if.current_state, u_if.command, u_if.command_valid); end
        ack();
        n_cmp++;
        if (u_if.command_valid !== 1'b0 || u_if.command !== 3'd0) begin n_bad++;
            $display("FAIL hangup_ack: cmd=%0d valid=%0b required 0/0", u_if.command, u_if.command_valid); end
        ack();
        n_cmp++;
        if (u_if.command_valid !== 1'b0 || u_if.current_state !== 3'd1) begin n_bad++;
            $display("FAIL idle_ack_ignored: state=%0d valid=%0b required 1/0", u_if.current_state, u_if.command_valid); end
    endtask

    task automatic test_dialing();
        press(2);
        press(0);
        n_cmp++;
        if (u_if.current_state !== 3'd3 || u_if.digit_count !== 3'd0 || u_if.phn_num !== 16'h0) begin n_bad++;
            $display("FAIL dial_entry: state=%0d cnt=%0d phn=%h required 3/0/0000",
                     u_if.current_state, u_if.digit_count, u_if.phn_num); end
        key(4'd11);
        press(0);
        n_cmp++;
        if (u_if.digit_count !== 3'd0 || u_if.current_state !== 3'd3 || u_if.command_valid !== 1'b0) begin n_bad++;
            $display("FAIL dial_bad_digit_empty_enter: state=%0d cnt=%0d valid=%0b required 3/0/0",
                     u_if.current_state, u_if.digit_count, u_if.command_valid); end
        key(4'd5); key(4'd5); key(4'd5); key(4'd1); key(4'd2);
        n_cmp++;
        if (u_if.phn_num !== 16'h1555 || u_if.digit_count !== 3'd4) begin n_bad++;
            $display("FAIL dial_full: phn=%h cnt=%0d required 1555/4", u_if.phn_num, u_if.digit_count); end
        press(1);
        n_cmp++;
        if (u_if.phn_num !== 16'h0555 || u_if.digit_count !== 3'd3 || u_if.current_state !== 3'd3) begin n_bad++;
            $display("FAIL dial_backspace: phn=%h cnt=%0d state=%0d required 0555/3/3",
                     u_if.phn_num, u_if.digit_count, u_if.current_state); end
    endtask

    task automatic test_ring_timeout();
        press(0);
        n_cmp++;
        if (u_if.current_state !== 3'd4 || u_if.command !== 3'd1 || u_if.command_valid !== 1'b1) begin n_bad++;
            $display("FAIL call_issue: state=%0d cmd=%0d valid=%0b required 4/1/1",
                     u_if.current_state, u_if.command, u_if.command_valid); end
        repeat (19) tick();
        n_cmp++;
        if (u_if.current_state !== 3'd4 || u_if.timed_out !== 1'b0 || u_if.command !== 3'd1) begin n_bad++;
            $display("FAIL ring_before_tc: state=%0d to=%0b cmd=%0d required 4/0/1",
                     u_if.current_state, u_if.timed_out, u_if.command); end
        tick();
        n_cmp++;
        if (u_if.current_state !== 3'd7 || u_if.timed_out !== 1'b1 || u_if.command !== 3'd4 ||
            u_if.command_valid !== 1'b1) begin n_bad++;
            $display("FAIL ring_timeout: state=%0d to=%0b cmd=%0d valid=%0b required 7/1/4/1",
                     u_if.current_state, u_if.timed_out, u_if.command, u_if.command_valid); end
        tick();
        n_cmp++;
        if (u_if.timed_out !== 1'b0 || u_if.current_state !== 3'd7) begin n_bad++;
            $display("FAIL timeout_pulse: state=%0d to=%0b required 7/0", u_if.current_state, u_if.timed_out); end
        repeat (18) tick();
        n_cmp++;
        if (u_if.current_state !== 3'd7) begin n_bad++;
            $display("FAIL ending_before_tc: state=%0d required 7", u_if.current_state); end
        tick();
        n_cmp++;
        if (u_if.current_state !== 3'd1 || u_if.timed_out !== 1'b1 || u_if.command !== 3'd4) begin n_bad++;
            $display("FAIL ending_timeout: state=%0d to=%0b cmd=%0d required 1/1/4",
                     u_if.current_state, u_if.timed_out, u_if.command); end
        ack();
    endtask

    task automatic test_incoming_timeout();
        status(3'd5);
        repeat (19) tick();
        n_cmp++;
        if (u_if.current_state !== 3'd5) begin n_bad++;
            $display("FAIL incoming_before_tc: state=%0d required 5", u_if.current_state); end
        tick();
        n_cmp++;
        if (u_if.current_state !== 3'd1 || u_if.timed_out !== 1'b1 || u_if.command_valid !== 1'b0) begin n_bad++;
            $display("FAIL incoming_timeout: state=%0d to=%0b valid=%0b required 1/1/0",
                     u_if.current_state, u_if.timed_out, u_if.command_valid); end
    endtask

    task automatic test_reset_mid_call();
        press(2);
        press(0);
        key(4'd7);
        press(0);
        n_cmp++;
        if (u_if.current_state !== 3'd4 || u_if.command_valid !== 1'b1 || u_if.phn_num !== 16'h0007) begin n_bad++;
            $display("FAIL mid_call_setup: state=%0d valid=%0b phn=%h required 4/1/0007",
                     u_if.current_state, u_if.command_valid, u_if.phn_num); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (u_if.current_state !== 3'd0 || u_if.command_valid !== 1'b0 || u_if.command !== 3'd0 ||
            u_if.phn_num !== 16'h0 || u_if.digit_count !== 3'd0) begin n_bad++;
            $display("FAIL reset_mid_call: state=%0d valid=%0b cmd=%0d phn=%h cnt=%0d required 0/0/0/0000/0",
                     u_if.current_state, u_if.command_valid, u_if.command, u_if.phn_num, u_if.digit_count); end
        press(5);
        n_cmp++;
        if (u_if.current_state !== 3'd1) begin n_bad++;
            $display("FAIL init_pulse: state=%0d required 1", u_if.current_state); end
    endtask

    initial begin
        u_if.init = 1'b0; u_if.enter = 1'b0; u_if.up = 1'b0; u_if.down = 1'b0;
        u_if.left = 1'b0; u_if.right = 1'b0; u_if.digit_valid = 1'b0;
        u_if.digit = 4'd0; u_if.inc_command = 3'd0; u_if.cmd_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        test_reset();
        test_menu();
        test_incoming_accept();
        test_busy_hangup();
        test_dialing();
        test_ring_timeout();
        test_incoming_timeout();
        test_reset_mid_call();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
